// File: rtl/seq_code_decoder_pkg.sv
// seq_code_decoder_pkg
//   Shared types and helpers for the registered code decoder and related
//   strobe generators.
//   - state_t       : pulse-mode FSM states (IDLE, HOLD)
//   - CNT_W         : width of the hold counter (holds up to 255 cycles)
//   - MAX_OUT       : widest decoded word the helpers can build
//   - inactive_word : word with every existing line at its inactive level
//   - onehot        : word with only line 'code' asserted, if it exists
package seq_code_decoder_pkg;

  localparam int CNT_W   = 8;
  localparam int MAX_OUT = 256;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bits at or above n_out are left 0; callers slice off the lines they own.
  function automatic logic [MAX_OUT-1:0] inactive_word(input int n_out, input bit active_low);
    logic [MAX_OUT-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (i < n_out) w[i] = active_low;
    end
    return w;
  endfunction

  // A code that names a non-existent line yields the all-inactive word.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [7:0] code, input int n_out,
                                                input bit active_low);
    logic [MAX_OUT-1:0] w;
    w = inactive_word(n_out, active_low);
    if (int'(code) < n_out) w[code] = ~active_low;
    return w;
  endfunction

endpackage

// File: rtl/seq_code_decoder_hold_timer.sv
// hold_timer
//   Loadable down-counter used to time strobe widths.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset (clears the count)
//     load        : load load_value this cycle (takes priority over dec)
//     load_value  : value to load
//     dec         : decrement by one; saturates at zero
//     value       : current count
//     last        : count == 1 (final cycle of a timed interval)
//     zero        : count == 0
module hold_timer
  import seq_code_decoder_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         last,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_value;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign value = cnt_reg;
  assign last  = (cnt_reg == W'(1));
  assign zero  = (cnt_reg == '0);

endmodule

// File: rtl/seq_code_decoder.sv
// seq_code_decoder
//   Registered SEL_W-bit to N_OUT-line decoder with a valid/ready input.
//   An accepted in-range code asserts exactly one line, either for
//   HOLD_CYCLES cycles (pulse mode) or until the next accept (HOLD_CYCLES=0,
//   level mode). Codes >= N_OUT are consumed, drive all lines inactive and
//   raise err for one cycle plus err_sticky until err_clr.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     in_valid    : code_in is valid
//     in_ready    : a code can be accepted this cycle
//     code_in     : code to decode
//     dec_out     : decoded lines, asserted level set by ACTIVE_LOW
//     busy        : a timed line is asserted (pulse mode only)
//     err         : one-cycle pulse after an out-of-range accept
//     err_sticky  : set by err, cleared by err_clr (set has priority)
//     err_clr     : clears err_sticky
module seq_code_decoder
  import seq_code_decoder_pkg::*;
#(
  parameter int SEL_W       = 4,
  parameter int N_OUT       = 10,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int HOLD_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] code_in,
  output logic [N_OUT-1:0] dec_out,
  output logic             busy,
  output logic             err,
  output logic             err_sticky,
  input  logic             err_clr
);

  localparam bit              PULSE     = (HOLD_CYCLES != 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  state_t             state_reg, state_next;
  logic [N_OUT-1:0]   dec_reg, dec_next;
  logic               err_reg, err_next;
  logic               err_sticky_reg, err_sticky_next;

  logic               tmr_load, tmr_dec, tmr_last, tmr_zero;
  logic [CNT_W-1:0]   tmr_load_value, tmr_value;

  logic [MAX_OUT-1:0] idle_word, code_word;
  logic [N_OUT-1:0]   idle_lines, code_lines;
  logic [7:0]         code8;
  logic               in_range, accept;
  logic               unused_bits;

  // Any in-range code fits in 8 bits because N_OUT <= MAX_OUT; wider codes
  // are only needed for the range comparison, which uses code_in directly.
  generate
    if (SEL_W >= 8) begin : g_code_trunc
      assign code8 = code_in[7:0];
    end else begin : g_code_pad
      assign code8 = {{(8 - SEL_W){1'b0}}, code_in};
    end
  endgenerate

  assign idle_word  = inactive_word(N_OUT, ACTIVE_LOW);
  assign code_word  = onehot(code8, N_OUT, ACTIVE_LOW);
  assign idle_lines = idle_word[N_OUT-1:0];
  assign code_lines = code_word[N_OUT-1:0];
  assign in_range   = (int'(code_in) < N_OUT);

  // In pulse mode a new code may land on the final hold cycle so that
  // back-to-back pulses join without an inactive gap.
  assign in_ready = ~rst & (~PULSE | (state_reg == IDLE) | tmr_last);
  assign accept   = in_valid & in_ready;

  hold_timer #(.W(CNT_W)) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .dec        (tmr_dec),
    .value      (tmr_value),
    .last       (tmr_last),
    .zero       (tmr_zero)
  );

  always_comb begin
    state_next     = state_reg;
    dec_next       = dec_reg;
    err_next       = 1'b0;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    tmr_dec        = 1'b0;

    if (accept) begin
      if (in_range) begin
        dec_next       = code_lines;
        tmr_load       = PULSE;
        tmr_load_value = HOLD_LOAD;
        state_next     = PULSE ? HOLD : IDLE;
      end else begin
        // Bad code abandons any running hold and blanks the outputs.
        dec_next       = idle_lines;
        err_next       = 1'b1;
        tmr_load       = 1'b1;
        tmr_load_value = '0;
        state_next     = IDLE;
      end
    end else if (state_reg == HOLD) begin
      tmr_dec = 1'b1;
      if (tmr_last) begin
        state_next = IDLE;
        dec_next   = idle_lines;
      end
    end

    err_sticky_next = err_next | (err_sticky_reg & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      dec_reg        <= idle_lines;
      err_reg        <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dec_reg        <= dec_next;
      err_reg        <= err_next;
      err_sticky_reg <= err_sticky_next;
    end
  end

  assign dec_out    = dec_reg;
  assign busy       = (state_reg == HOLD);
  assign err        = err_reg;
  assign err_sticky = err_sticky_reg;

  // Helper words are MAX_OUT wide; only the low N_OUT bits carry lines.
  assign unused_bits = ^{idle_word, code_word, tmr_value, tmr_zero};

endmodule

// File: tb/tb_seq_code_decoder.sv
// tb_seq_code_decoder
//   Two decoders share one stimulus stream:
//     d0 : defaults (N_OUT=10, ACTIVE_LOW=1, HOLD_CYCLES=3)
//     d1 : level mode (N_OUT=16, ACTIVE_LOW=0, HOLD_CYCLES=0)
//   The driver advances a behavioural model per cycle and queues the
//   expected outputs; the monitor pops and compares one entry per cycle.
module tb_seq_code_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] code_in = 4'd0;

  logic        ready0, busy0, err0, sticky0;
  logic [9:0]  dec0;
  logic        ready1, busy1, err1, sticky1;
  logic [15:0] dec1;

  seq_code_decoder #(.SEL_W(4), .N_OUT(10), .ACTIVE_LOW(1'b1), .HOLD_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready0), .code_in(code_in),
    .dec_out(dec0), .busy(busy0), .err(err0), .err_sticky(sticky0), .err_clr(err_clr)
  );

  seq_code_decoder #(.SEL_W(4), .N_OUT(16), .ACTIVE_LOW(1'b0), .HOLD_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready1), .code_in(code_in),
    .dec_out(dec1), .busy(busy1), .err(err1), .err_sticky(sticky1), .err_clr(err_clr)
  );

  typedef struct {
    logic [15:0] dec;
    logic        busy;
    logic        err;
    logic        sticky;
    logic        ready;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  // Model: which line is asserted (-1 = none) and how many asserted cycles remain.
  int m_line[2];
  int m_rem[2];
  bit m_err[2];
  bit m_sticky[2];

  task automatic model_step(input int d, input bit r, input bit v, input int c, input bit clr,
                            output exp_t e, output bit acc);
    int n, hold;
    bit al, rdy;
    n    = (d == 0) ? 10 : 16;
    hold = (d == 0) ? 3 : 0;
    al   = (d == 0);
    acc  = 1'b0;
    if (r) begin
      m_line[d] = -1; m_rem[d] = 0; m_err[d] = 0; m_sticky[d] = 0;
    end else begin
      rdy = (hold == 0) || (m_rem[d] <= 1);
      acc = v && rdy;
      m_err[d] = 0;
      if (acc) begin
        if (c < n) begin
          m_line[d] = c; m_rem[d] = hold;
        end else begin
          m_line[d] = -1; m_rem[d] = 0; m_err[d] = 1;
        end
      end else if (hold > 0 && m_rem[d] > 0) begin
        m_rem[d]--;
        if (m_rem[d] == 0) m_line[d] = -1;
      end
      m_sticky[d] = m_err[d] | (m_sticky[d] & ~clr);
    end
    e.dec = '0;
    for (int i = 0; i < n; i++) e.dec[i] = (i == m_line[d]) ? ~al : al;
    e.busy   = (hold > 0) && (m_rem[d] > 0);
    e.err    = m_err[d];
    e.sticky = m_sticky[d];
    e.ready  = !r && ((hold == 0) || (m_rem[d] <= 1));
  endtask

  task automatic drive(input bit r, input bit v, input int c, input bit clr);
    exp_t e0, e1;
    bit a0, a1;
    @(negedge clk);
    #1;
    rst = r; in_valid = v; code_in = 4'(c); err_clr = clr;
    model_step(0, r, v, c, clr, e0, a0);
    model_step(1, r, v, c, clr, e1, a1);
    q0.push_back(e0);
    q1.push_back(e1);
    if (a0 || a1)
      $display("txn t=%0t code=%0d d0_accept=%0d d1_accept=%0d clr=%0d", $time, c, a0, a1, clr);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("d0_dec",    {6'd0, dec0},    e.dec);
      check("d0_busy",   {15'd0, busy0},  {15'd0, e.busy});
      check("d0_err",    {15'd0, err0},   {15'd0, e.err});
      check("d0_sticky", {15'd0, sticky0}, {15'd0, e.sticky});
      check("d0_ready",  {15'd0, ready0}, {15'd0, e.ready});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("d1_dec",    dec1,            e.dec);
      check("d1_busy",   {15'd0, busy1},  {15'd0, e.busy});
      check("d1_err",    {15'd0, err1},   {15'd0, e.err});
      check("d1_sticky", {15'd0, sticky1}, {15'd0, e.sticky});
      check("d1_ready",  {15'd0, ready1}, {15'd0, e.ready});
    end
  end

  initial begin
    // reset and idle
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0);
    // single pulse on line 5
    drive(0, 1, 5, 0);
    repeat (4) drive(0, 0, 0, 0);
    // 2 then 7 as soon as ready rises
    drive(0, 1, 2, 0);
    repeat (3) drive(0, 1, 7, 0);
    repeat (4) drive(0, 0, 0, 0);
    // 2 then 2: six continuous cycles
    drive(0, 1, 2, 0);
    repeat (3) drive(0, 1, 2, 0);
    repeat (4) drive(0, 0, 0, 0);
    // out-of-range, sticky, clear racing a new error
    drive(0, 1, 12, 0);
    repeat (2) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 1, 15, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    // bad code abandons a running hold
    drive(0, 1, 3, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 11, 0);
    repeat (3) drive(0, 0, 0, 0);
    // reset mid-hold
    drive(0, 1, 4, 0);
    drive(0, 0, 0, 0);
    drive(1, 1, 6, 0);
    drive(1, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    // level-mode pattern: 0 then 15
    drive(0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(0, 1, 15, 0);
    repeat (3) drive(0, 0, 0, 0);
    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(1) == 1),
            int'($urandom_range(15)), ($urandom_range(15) == 0));
    end
    repeat (3) drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    check("q0_drain", 16'(q0.size()), 16'd0);
    check("q1_drain", 16'(q1.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_code_decoder.md
Name: seq_code_decoder

Overview:
- Parametrised, registered successor to the team's combinational 4-to-10 active-low code decoder.
- Accepts a SEL_W-bit code over a valid/ready handshake and drives exactly one of N_OUT decoded lines.
- The line is held for HOLD_CYCLES cycles, or latched until the next code when HOLD_CYCLES=0.
- Out-of-range codes are flagged rather than silently decoded; used as a strobe/select generator in front of banked logic.

Parameters:
- SEL_W, 4, code width in bits.
- N_OUT, 10, number of decoded lines; legal range 2..2**SEL_W.
- ACTIVE_LOW, 1, 1 = asserted line driven 0 and inactive lines 1; 0 = inverse.
- HOLD_CYCLES, 3, cycles a decoded line stays asserted; 0 = level mode (held until next accept); max 255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  code_in is valid.
- in_ready  out  1  block can accept a code this cycle.
- code_in  in  SEL_W  code to decode.
- dec_out  out  N_OUT  decoded lines, polarity per ACTIVE_LOW.
- busy  out  1  a line is currently asserted in pulse mode.
- err  out  1  one-cycle pulse: an out-of-range code (code_in >= N_OUT) was accepted.
- err_sticky  out  1  set by err, cleared by err_clr or rst.
- err_clr  in  1  clears err_sticky.

Behaviour:
- Reset (rst=1 at an edge): dec_out = all inactive (all ones if ACTIVE_LOW=1, all zeros otherwise), busy=0, err=0, err_sticky=0, hold counter=0, state=IDLE. in_ready=0 while rst is high.
- Accept: in_valid & in_ready at rising edge t. All outputs are registered, so the response appears from cycle t+1.
- Pulse mode (HOLD_CYCLES>0):
  - States: IDLE and HOLD.
  - IDLE plus a valid in-range accept: go to HOLD, load cnt=HOLD_CYCLES, assert line code_in on dec_out, busy=1.
  - In HOLD, cnt decrements each cycle.
  - When cnt reaches 1 with no accept: next cycle returns to IDLE with dec_out all inactive and busy=0.
  - Total asserted duration is exactly HOLD_CYCLES cycles.
  - in_ready = (state==IDLE) | (cnt==1), so back-to-back accepts give seamless pulses with no inactive gap.
  - If the new code equals the old one, the line stays asserted continuously for 2*HOLD_CYCLES cycles.
- Level mode (HOLD_CYCLES=0): in_ready=1 whenever rst=0. dec_out holds the last accepted in-range code indefinitely. busy stays 0.
- Out-of-range code (code_in >= N_OUT):
  - Still consumes the handshake. err=1 for cycle t+1 only; err_sticky set.
  - dec_out is forced to all-inactive from t+1.
  - Pulse mode: the block goes to IDLE, abandoning any running hold.
- err_clr and a new error in the same cycle: set wins, err_sticky=1.
- At most one dec_out bit is asserted in any cycle (one-hot, or zero-hot for active-low).
- Code width: code_in is compared unsigned against N_OUT. Lines N_OUT..2**SEL_W-1 do not exist.
- Reset mid-hold: the next cycle is all-inactive and the counter is cleared. No residual pulse after rst deasserts.
- in_valid while in_ready=0 is ignored, with no side effects. The source must hold code_in until it is accepted.

Decomposition:
- Shared package seq_code_decoder_pkg holds:
  - state enum {IDLE, HOLD}
  - function inactive_word(N_OUT, ACTIVE_LOW)
  - function onehot(code, N_OUT, ACTIVE_LOW)
  - constant CNT_W = 8
- One sub-module, hold_timer: a loadable down-counter with load, value, last (cnt==1) and zero outputs. It is reused by future strobe generators.
- Decode logic stays in the top module.

Test Plan:
- Post-reset, defaults (N_OUT=10, ACTIVE_LOW=1, HOLD=3): dec_out=10'h3FF, in_ready=1, busy=0, err=0.
- Accept code 5 at t -> dec_out=10'b11_1101_1111 on cycles t+1..t+3, 10'h3FF at t+4; busy high t+1..t+3; in_ready low at t+1, t+2 and high at t+3.
- Accept 2, then 7 as soon as in_ready rises -> bit2 low for 3 cycles, then bit7 low for 3 cycles with no all-ones cycle between; 2 then 2 gives bit2 low for 6 consecutive cycles.
- Accept code 12 (0xC) -> err=1 for exactly one cycle, dec_out stays 10'h3FF, err_sticky=1 until err_clr; err_clr and code 15 in the same cycle leave err_sticky=1.
- rst asserted while code 4 is held (t+2) -> 10'h3FF the following cycle, busy=0, in_ready=0 during rst, no pulse resumes after release.
- HOLD_CYCLES=0, ACTIVE_LOW=0, N_OUT=16: accept 0 then 15 -> dec_out=16'h0001 held until the second accept, then 16'h8000 held; in_ready constantly 1, busy 0.
